// File: rtl/rl_ram_1r1w_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// rl_ram_1r1w_fifo_ctrl
//
// First-word-fall-through FIFO controller for an external 1R1W RAM with a
// registered read address and unregistered read data (1-cycle read latency).
// The controller owns the pointers, occupancy count, status flags and the
// write-to-read collision bypass. The RAM itself lives in the parent.
//
// Ports:
//   rst_ni          async active-low reset
//   clk_i           clock, rising edge
//   clr_i           synchronous flush, overrides push/pop
//   push_i, din_i   write request and data
//   pop_i           read acknowledge, consumes dout_o
//   dout_o          head-of-FIFO data, valid while empty_o=0
//   empty_o/full_o  occupancy flags
//   almost_empty_o  cnt_o <= AEMPTY_LVL
//   almost_full_o   cnt_o >= AFULL_LVL
//   cnt_o           occupancy 0..2**ABITS
//   overflow_o      1-cycle pulse after a rejected push
//   underflow_o     1-cycle pulse after a rejected pop
//   ram_*           RAM write port, byte enables and read address/data
// ---------------------------------------------------------------------------
module rl_ram_1r1w_fifo_ctrl #(
  parameter int unsigned ABITS      = 4,
  parameter int unsigned DBITS      = 32,
  parameter int unsigned AFULL_LVL  = 2**ABITS - 2,
  parameter int unsigned AEMPTY_LVL = 1
) (
  input  logic                   rst_ni,
  input  logic                   clk_i,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [DBITS-1:0]       din_i,
  input  logic                   pop_i,
  output logic [DBITS-1:0]       dout_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic                   almost_empty_o,
  output logic                   almost_full_o,
  output logic [ABITS:0]         cnt_o,
  output logic                   overflow_o,
  output logic                   underflow_o,
  output logic [ABITS-1:0]       ram_waddr_o,
  output logic [DBITS-1:0]       ram_din_o,
  output logic                   ram_we_o,
  output logic [(DBITS+7)/8-1:0] ram_be_o,
  output logic [ABITS-1:0]       ram_raddr_o,
  input  logic [DBITS-1:0]       ram_dout_i
);

  localparam logic [ABITS:0] DEPTH_C = {1'b1, {ABITS{1'b0}}};

  logic [ABITS-1:0] r_wp;
  logic [ABITS-1:0] r_rp;
  logic [ABITS:0]   r_cnt;
  logic             r_empty;
  logic             r_full;
  logic             r_aempty;
  logic             r_afull;
  logic             r_ovf;
  logic             r_udf;
  logic             r_byp_sel;
  logic [DBITS-1:0] r_byp_q;

  logic             w_push_acc;
  logic             w_pop_acc;
  logic [ABITS-1:0] w_rp_nxt;
  logic [ABITS:0]   w_cnt_nxt;
  logic             w_collide;

  // A flush cycle accepts nothing, so no RAM write happens while clearing.
  assign w_push_acc = push_i & ~r_full  & ~clr_i;
  assign w_pop_acc  = pop_i  & ~r_empty & ~clr_i;

  // Read address looks one entry ahead on a pop so the RAM output already
  // holds the new head in the following cycle (zero pop-to-data latency).
  assign w_rp_nxt = r_rp + ABITS'(w_pop_acc);

  // Mixed-port read-during-write is undefined in the RAM; capture the write
  // data instead and present it for the cycle the RAM output is unreliable.
  assign w_collide = w_push_acc & (r_wp == w_rp_nxt);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr_i) begin
      w_cnt_nxt = '0;
    end else begin
      unique case ({w_push_acc, w_pop_acc})
        2'b10:   w_cnt_nxt = r_cnt + 1'b1;
        2'b01:   w_cnt_nxt = r_cnt - 1'b1;
        default: w_cnt_nxt = r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_aempty  <= 1'b1;
      r_afull   <= 1'b0;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
      r_byp_sel <= 1'b0;
      r_byp_q   <= '0;
    end else begin
      // Flags are registered from the next count: no input-to-flag path.
      r_cnt    <= w_cnt_nxt;
      r_empty  <= (w_cnt_nxt == '0);
      r_full   <= (w_cnt_nxt == DEPTH_C);
      r_aempty <= (32'(w_cnt_nxt) <= AEMPTY_LVL);
      r_afull  <= (32'(w_cnt_nxt) >= AFULL_LVL);
      if (clr_i) begin
        r_wp      <= '0;
        r_rp      <= '0;
        r_ovf     <= 1'b0;
        r_udf     <= 1'b0;
        r_byp_sel <= 1'b0;
      end else begin
        if (w_push_acc) begin
          r_wp <= r_wp + 1'b1;
        end
        r_rp      <= w_rp_nxt;
        r_ovf     <= push_i & r_full;
        r_udf     <= pop_i & r_empty;
        r_byp_sel <= w_collide;
        if (w_collide) begin
          r_byp_q <= din_i;
        end
      end
    end
  end

  assign dout_o         = r_byp_sel ? r_byp_q : ram_dout_i;
  assign empty_o        = r_empty;
  assign full_o         = r_full;
  assign almost_empty_o = r_aempty;
  assign almost_full_o  = r_afull;
  assign cnt_o          = r_cnt;
  assign overflow_o     = r_ovf;
  assign underflow_o    = r_udf;

  assign ram_we_o    = w_push_acc;
  assign ram_waddr_o = r_wp;
  assign ram_din_o   = din_i;
  assign ram_be_o    = '1;
  assign ram_raddr_o = w_rp_nxt;

endmodule

// File: tb/tb_rl_ram_1r1w_fifo_ctrl.sv
module tb_rl_ram_1r1w_fifo_ctrl;

  localparam int unsigned ABITS = 4;
  localparam int unsigned DBITS = 32;
  localparam int unsigned DEPTH = 16;

  logic              rst_ni = 1'b0;
  logic              clk_i  = 1'b0;
  logic              clr_i  = 1'b0;
  logic              push_i = 1'b0;
  logic [DBITS-1:0]  din_i  = '0;
  logic              pop_i  = 1'b0;
  logic [DBITS-1:0]  dout_o;
  logic              empty_o, full_o, almost_empty_o, almost_full_o;
  logic [ABITS:0]    cnt_o;
  logic              overflow_o, underflow_o;
  logic [ABITS-1:0]  ram_waddr_o, ram_raddr_o;
  logic [DBITS-1:0]  ram_din_o, ram_dout_i;
  logic              ram_we_o;
  logic [3:0]        ram_be_o;

  always #5 clk_i = ~clk_i;

  rl_ram_1r1w_fifo_ctrl #(.ABITS(ABITS), .DBITS(DBITS), .AFULL_LVL(14), .AEMPTY_LVL(1)) dut (
    .rst_ni(rst_ni), .clk_i(clk_i), .clr_i(clr_i), .push_i(push_i), .din_i(din_i),
    .pop_i(pop_i), .dout_o(dout_o), .empty_o(empty_o), .full_o(full_o),
    .almost_empty_o(almost_empty_o), .almost_full_o(almost_full_o), .cnt_o(cnt_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o), .ram_waddr_o(ram_waddr_o),
    .ram_din_o(ram_din_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
    .ram_raddr_o(ram_raddr_o), .ram_dout_i(ram_dout_i)
  );

  // RAM model: registered read address, unregistered data; a same-address
  // read-during-write returns garbage so a missing bypass is visible.
  logic [DBITS-1:0] mem [DEPTH];
  logic [ABITS-1:0] raddr_q = '0;
  logic             coll_q  = 1'b0;
  always @(posedge clk_i) begin
    if (ram_we_o) mem[ram_waddr_o] <= ram_din_o;
    raddr_q <= ram_raddr_o;
    coll_q  <= ram_we_o && (ram_waddr_o == ram_raddr_o);
  end
  assign ram_dout_i = coll_q ? 32'hDEAD_BEEF : mem[raddr_q];

  // Reference model: a queue of stored words plus expected pulse flags.
  logic [DBITS-1:0] mq[$];
  logic             e_ovf = 1'b0;
  logic             e_udf = 1'b0;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("cnt", 32'(cnt_o), 32'(mq.size()));
    chk("empty", 32'(empty_o), 32'(mq.size() == 0));
    chk("full", 32'(full_o), 32'(mq.size() == DEPTH));
    chk("aempty", 32'(almost_empty_o), 32'(mq.size() <= 1));
    chk("afull", 32'(almost_full_o), 32'(mq.size() >= DEPTH - 2));
    chk("ovf", 32'(overflow_o), 32'(e_ovf));
    chk("udf", 32'(underflow_o), 32'(e_udf));
    if (mq.size() > 0) chk("dout", dout_o, mq[0]);
  endtask

  task automatic step(input logic ps, input logic pp, input logic cl, input logic [31:0] d);
    logic pa, qa, exp_we;
    @(negedge clk_i);
    push_i = ps; pop_i = pp; clr_i = cl; din_i = d;
    #1;
    exp_we = !cl && ps && (mq.size() < DEPTH);
    chk("ram_we", 32'(ram_we_o), 32'(exp_we));
    if (exp_we) chk("ram_din", ram_din_o, d);
    @(posedge clk_i);
    if (cl) begin
      mq.delete();
      e_ovf = 1'b0;
      e_udf = 1'b0;
    end else begin
      pa = ps && (mq.size() < DEPTH);
      qa = pp && (mq.size() > 0);
      e_ovf = ps && !pa;
      e_udf = pp && !qa;
      if (qa) void'(mq.pop_front());
      if (pa) mq.push_back(d);
    end
    #1;
    check_model();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cnt"}, 32'(cnt_o), 0);
    chk({tag, "_empty"}, 32'(empty_o), 1);
    chk({tag, "_full"}, 32'(full_o), 0);
    chk({tag, "_aempty"}, 32'(almost_empty_o), 1);
    chk({tag, "_afull"}, 32'(almost_full_o), 0);
    chk({tag, "_ovf"}, 32'(overflow_o), 0);
    chk({tag, "_udf"}, 32'(underflow_o), 0);
  endtask

  typedef struct {
    logic        ps, pp, cl;
    logic [31:0] d;
    int unsigned cnt;
    logic        emp, ovf, udf, dchk;
    logic [31:0] dout;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // Hand-derived vectors starting from an empty FIFO.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'hA5A5_A5A5, 1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_A5A5};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h0,         0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h1111_1111, 1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1111_1111};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h2222_2222, 1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2222_2222};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h3333_3333, 2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2222_2222};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0,         1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3333_3333};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 32'h4444_4444, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 32'h0,         0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 32'h5555_5555, 1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h5555_5555};

    #12;
    check_reset_vals("rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    chk("ram_be", 32'(ram_be_o), 32'hF);

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].ps, tbl[i].pp, tbl[i].cl, tbl[i].d);
      chk("tbl_cnt", 32'(cnt_o), tbl[i].cnt);
      chk("tbl_empty", 32'(empty_o), 32'(tbl[i].emp));
      chk("tbl_ovf", 32'(overflow_o), 32'(tbl[i].ovf));
      chk("tbl_udf", 32'(underflow_o), 32'(tbl[i].udf));
      if (tbl[i].dchk) chk("tbl_dout", dout_o, tbl[i].dout);
    end
    step(1'b0, 1'b1, 1'b0, 0);

    // Fill to full, rejected pushes, push+pop at full, then drain.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 32'(i));
    chk("fill_full", 32'(full_o), 1);
    chk("fill_cnt", 32'(cnt_o), 16);
    step(1'b1, 1'b0, 1'b0, 32'h99);
    chk("ovf_pulse", 32'(overflow_o), 1);
    chk("ovf_cnt", 32'(cnt_o), 16);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("ovf_clear", 32'(overflow_o), 0);
    step(1'b1, 1'b1, 1'b0, 32'hAB);
    chk("full_pp_cnt", 32'(cnt_o), 15);
    chk("full_pp_ovf", 32'(overflow_o), 1);
    chk("full_pp_dout", dout_o, 32'h1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 0);
    chk("drain_empty", 32'(empty_o), 1);

    // Continuous push+pop stream through an empty FIFO, then the cnt=5 case.
    step(1'b1, 1'b0, 1'b0, 32'hC000_0000);
    for (int i = 1; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'hC000_0000 + 32'(i));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'hD000_0000 + 32'(i));
    chk("cnt5", 32'(cnt_o), 5);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'hE000_0000 + 32'(i));
    chk("cnt5_hold", 32'(cnt_o), 5);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 0);

    // Wrap-around at occupancy 3.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h100 + 32'(i));
    for (int i = 3; i < 43; i++) step(1'b1, 1'b1, 1'b0, 32'h100 + 32'(i));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 0);

    // Clear with push at cnt=7.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 32'h700 + 32'(i));
    step(1'b1, 1'b0, 1'b1, 32'h777);
    chk("clr_cnt", 32'(cnt_o), 0);
    chk("clr_empty", 32'(empty_o), 1);

    // Asynchronous reset in the middle of a push burst.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h800 + 32'(i));
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_vals("arst");
    mq.delete();
    e_ovf = 1'b0;
    e_udf = 1'b0;
    @(negedge clk_i);
    push_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(1'b1, 1'b0, 1'b0, 32'h1);
    chk("post_rst_dout", dout_o, 32'h1);
    step(1'b0, 1'b1, 1'b0, 0);

    // Randomized traffic with phase-dependent bias and rare clears.
    for (int i = 0; i < 3000; i++) begin
      int unsigned pp_bias;
      int unsigned ps_bias;
      pp_bias = ((i / 200) % 3 == 0) ? 30 : (((i / 200) % 3 == 1) ? 70 : 50);
      ps_bias = 100 - pp_bias;
      step($urandom_range(0, 99) < ps_bias, $urandom_range(0, 99) < pp_bias,
           $urandom_range(0, 127) == 0, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
